seg_scan_driver: RTL and testbench

Multiplexed N-digit seven-segment display driver. It is the parametrised successor of the single-digit hex decoder: it scans DIGITS common-anode/cathode digits with a registered, time-sliced digit select. It also adds decimal points, per-digit enable, leading-zero blanking, anti-ghost blanking gaps and tear-free frame-synchronous data update. It sits between the application datapath (counters, BCD converters) and the board's segment/select pins.

---
 rtl/seg_scan_driver_pkg.sv | 17 +
 rtl/seg_scan_driver_if.sv | 36 +++
 rtl/seg_scan_driver_hex_lut.sv | 15 +
 rtl/seg_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//   SEG_HEX : 0-F glyph table, gfedcba, active-low (bit = 0 lights the segment)
//   SEG_OFF : all segments dark in active-low form
//   state_t : scan FSM states
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the glyph for nibble n (index 0 is the rightmost element).
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the application datapath and the scan driver.
//   upd/data_in/dp_in/en_in : update strobe and the frame it carries
//   seg_led/seg_dp/seg_sel  : board pins
//   frame_start/upd_pending : frame-sync status
//   dbg_state               : scan FSM state, for observation only
// Handshake: upd is a one-cycle valid with an implicit always-high ready;
// every asserted cycle is accepted and the data sampled with it is captured.
// The update takes effect at the next frame boundary; upd_pending reports
// that an accepted update has not yet reached the display.
interface seg_scan_if #(
  parameter int DIGITS = 6
);
  import seg_pkg::*;

  logic                  upd;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     en_in;
  logic [6:0]            seg_led;
  logic                  seg_dp;
  logic [DIGITS-1:0]     seg_sel;
  logic                  frame_start;
  logic                  upd_pending;
  state_t                dbg_state;

  modport master (
    output upd, data_in, dp_in, en_in,
    input  seg_led, seg_dp, seg_sel, frame_start, upd_pending, dbg_state
  );

  modport slave (
    input  upd, data_in, dp_in, en_in,
    output seg_led, seg_dp, seg_sel, frame_start, upd_pending, dbg_state
  );

endinterface

// File: rtl/seg_scan_driver_hex_lut.sv
// Combinational nibble to seven-segment decode.
//   nib : hex digit
//   seg : gfedcba, polarity set by SEG_ACTIVE_LOW
module seg7_hex_lut
  import seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_ACTIVE_LOW ? SEG_HEX[nib] : ~SEG_HEX[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver.
//   sys_clk/sys_rst : clock, asynchronous active-high reset
//   bus (slave)     : update inputs, segment/select pins, frame status
// Each digit slot is BLANK_CYC dark cycles followed by DWELL_CYC lit
// cycles. New data is held in pending registers and moved into the shadow
// (displayed) registers only when digit DIGITS-1 finishes, so a frame never
// mixes old and new data.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int DWELL_CYC      = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit LZB            = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  seg_scan_if.slave  bus
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_IDLE   = SEG_ACTIVE_LOW ? SEG_OFF : 7'h00;
  localparam logic              DP_IDLE    = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] SEL_IDLE   = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  state_t              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                show_start;

  logic [4*DIGITS-1:0] sh_data, sh_data_nxt, pend_data;
  logic [DIGITS-1:0]   sh_dp, sh_dp_nxt, pend_dp;
  logic [DIGITS-1:0]   sh_en, sh_en_nxt, pend_en;
  logic                pending, pending_nxt;
  logic                frame_end;

  logic [DIGITS-1:0]   dark;
  logic                lead;
  logic [3:0]          nib;
  logic                dp_bit, en_bit, dark_bit, lit;
  logic [DIGITS-1:0]   onehot;
  logic [6:0]          lut_seg;

  logic [6:0]          seg_led_q;
  logic                seg_dp_q;
  logic [DIGITS-1:0]   seg_sel_q;
  logic                frame_start_q;

  // Scan FSM next state. With BLANK_CYC=0 SHOW chains to SHOW; the single
  // BLANK cycle after reset is just the reset state leaving on the first edge.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt + CW'(1);
    show_start = 1'b0;
    case (state)
      ST_BLANK: begin
        if (BLANK_CYC == 0 || cnt == BLANK_LAST) begin
          state_nxt  = ST_SHOW;
          cnt_nxt    = '0;
          show_start = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_nxt = '0;
          idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          if (BLANK_CYC == 0) begin
            state_nxt  = ST_SHOW;
            show_start = 1'b1;
          end else begin
            state_nxt = ST_BLANK;
          end
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  assign frame_end = (state == ST_SHOW) && (cnt == DWELL_LAST) && (idx == IDX_LAST);

  // Shadow update. An upd landing on the boundary itself bypasses the
  // pending registers so it is neither lost nor delayed by a frame.
  always_comb begin
    sh_data_nxt = sh_data;
    sh_dp_nxt   = sh_dp;
    sh_en_nxt   = sh_en;
    pending_nxt = pending;
    if (frame_end) begin
      if (bus.upd) begin
        sh_data_nxt = bus.data_in;
        sh_dp_nxt   = bus.dp_in;
        sh_en_nxt   = bus.en_in;
      end else if (pending) begin
        sh_data_nxt = pend_data;
        sh_dp_nxt   = pend_dp;
        sh_en_nxt   = pend_en;
      end
      pending_nxt = 1'b0;
    end else if (bus.upd) begin
      pending_nxt = 1'b1;
    end
  end

  // Leading-zero mask: dark from the top down while nibble and dp are both
  // zero. Digit 0 is never part of the mask.
  always_comb begin
    dark = '0;
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead    = lead && (sh_data_nxt[4*k +: 4] == 4'h0) && !sh_dp_nxt[k];
      dark[k] = lead && LZB;
    end
  end

  // Outputs are decoded from next-cycle values so the registered pins
  // light up on the very first cycle of each SHOW.
  always_comb begin
    nib      = '0;
    dp_bit   = 1'b0;
    en_bit   = 1'b0;
    dark_bit = 1'b0;
    onehot   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib      = sh_data_nxt[4*k +: 4];
        dp_bit   = sh_dp_nxt[k];
        en_bit   = sh_en_nxt[k];
        dark_bit = dark[k];
      end
    end
    lit = (state_nxt == ST_SHOW) && en_bit && !dark_bit;
    for (int k = 0; k < DIGITS; k++) begin
      onehot[k] = lit && (idx_nxt == IW'(k));
    end
  end

  seg7_hex_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_lut (
    .nib (nib),
    .seg (lut_seg)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= ST_BLANK;
      idx           <= '0;
      cnt           <= '0;
      sh_data       <= '0;
      sh_dp         <= '0;
      sh_en         <= '0;
      pend_data     <= '0;
      pend_dp       <= '0;
      pend_en       <= '0;
      pending       <= 1'b0;
      seg_led_q     <= SEG_IDLE;
      seg_dp_q      <= DP_IDLE;
      seg_sel_q     <= SEL_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      sh_data <= sh_data_nxt;
      sh_dp   <= sh_dp_nxt;
      sh_en   <= sh_en_nxt;
      pending <= pending_nxt;
      if (bus.upd) begin
        pend_data <= bus.data_in;
        pend_dp   <= bus.dp_in;
        pend_en   <= bus.en_in;
      end
      seg_led_q     <= lit ? lut_seg : SEG_IDLE;
      seg_dp_q      <= (lit && dp_bit) ? ~DP_IDLE : DP_IDLE;
      seg_sel_q     <= SEL_ACTIVE_LOW ? ~onehot : onehot;
      frame_start_q <= show_start && (idx_nxt == '0);
    end
  end

  assign bus.seg_led     = seg_led_q;
  assign bus.seg_dp      = seg_dp_q;
  assign bus.seg_sel     = seg_sel_q;
  assign bus.frame_start = frame_start_q;
  assign bus.upd_pending = pending;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three 4-digit instances sharing clock/reset.
//   dut_a : DWELL 4, BLANK 2, no LZB   (scan timing, tear-free update, reset)
//   dut_b : DWELL 4, BLANK 2, LZB      (leading-zero blanking)
//   dut_c : DWELL 4, BLANK 0, no LZB   (enables, dp, back-to-back slots)
// Observed vector per cycle: {upd_pending, frame_start, seg_sel[3:0], seg_led[6:0], seg_dp}.
module tb_seg_scan_driver;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Update records are {en[3:0], dp[3:0], data[15:0]}.
  logic [23:0] exp_q_a[$];
  logic [23:0] exp_q_b[$];
  logic [23:0] exp_q_c[$];
  logic [23:0] cur [3];

  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(4)) if_a ();
  seg_scan_if #(.DIGITS(4)) if_b ();
  seg_scan_if #(.DIGITS(4)) if_c ();

  seg_scan_driver #(.DIGITS(4), .DWELL_CYC(4), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1'b1),
                    .SEL_ACTIVE_LOW(1'b1), .LZB(1'b0))
    dut_a (.sys_clk(clk), .sys_rst(rst), .bus(if_a));
  seg_scan_driver #(.DIGITS(4), .DWELL_CYC(4), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1'b1),
                    .SEL_ACTIVE_LOW(1'b1), .LZB(1'b1))
    dut_b (.sys_clk(clk), .sys_rst(rst), .bus(if_b));
  seg_scan_driver #(.DIGITS(4), .DWELL_CYC(4), .BLANK_CYC(0), .SEG_ACTIVE_LOW(1'b1),
                    .SEL_ACTIVE_LOW(1'b1), .LZB(1'b0))
    dut_c (.sys_clk(clk), .sys_rst(rst), .bus(if_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [13:0] obs(input int w);
    case (w)
      0: return {if_a.upd_pending, if_a.frame_start, if_a.seg_sel, if_a.seg_led, if_a.seg_dp};
      1: return {if_b.upd_pending, if_b.frame_start, if_b.seg_sel, if_b.seg_led, if_b.seg_dp};
      default: return {if_c.upd_pending, if_c.frame_start, if_c.seg_sel, if_c.seg_led, if_c.seg_dp};
    endcase
  endfunction

  // Expected pins at cycle t of a frame (t=0 is the first SHOW cycle of digit 0).
  function automatic logic [13:0] exp_vec(input logic [23:0] v, input bit lzb, input int blank,
                                          input int t, input logic pend);
    int slot, k;
    logic [3:0] dk;
    logic lead, lit;
    logic [3:0] sel;
    logic [6:0] led;
    logic dp;
    slot = 4 + blank;
    k    = t / slot;
    dk   = 4'b0000;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      lead  = lead && (v[4*i +: 4] == 4'h0) && (v[16+i] == 1'b0);
      dk[i] = lead && lzb;
    end
    lit = ((t % slot) < 4) && v[20+k] && !dk[k];
    sel = 4'hF;
    led = 7'h7F;
    dp  = 1'b1;
    if (lit) begin
      sel[k] = 1'b0;
      led    = exp_hex(v[4*k +: 4]);
      dp     = ~v[16+k];
    end
    return {pend, (t == 0), sel, led, dp};
  endfunction

  task automatic set_in(input int w, input logic u, input logic [23:0] v);
    case (w)
      0: begin if_a.upd = u; if_a.data_in = v[15:0]; if_a.dp_in = v[19:16]; if_a.en_in = v[23:20]; end
      1: begin if_b.upd = u; if_b.data_in = v[15:0]; if_b.dp_in = v[19:16]; if_b.en_in = v[23:20]; end
      default: begin if_c.upd = u; if_c.data_in = v[15:0]; if_c.dp_in = v[19:16]; if_c.en_in = v[23:20]; end
    endcase
  endtask

  // Driving an update also records what the display must show once it lands.
  task automatic drive_upd(input int w, input logic [23:0] v);
    set_in(w, 1'b1, v);
    case (w)
      0: exp_q_a.push_back(v);
      1: exp_q_b.push_back(v);
      default: exp_q_c.push_back(v);
    endcase
  endtask

  task automatic release_upd(input int w);
    case (w)
      0: if_a.upd = 1'b0;
      1: if_b.upd = 1'b0;
      default: if_c.upd = 1'b0;
    endcase
  endtask

  task automatic wait_frame(input int w, output int n);
    logic [13:0] o;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      o = obs(w);
    end while (!o[12] && n < 100);
    check($sformatf("fs_seen_w%0d", w), {31'd0, o[12]}, 32'd1);
  endtask

  // Check one whole frame cycle by cycle. A queued update becomes the
  // displayed data at the start of the frame after it was driven.
  task automatic check_frame(input int w, input int exp_wait, input int upd_t, input logic [23:0] nv);
    int n, blank, slot, fl, b;
    bit lzb;
    logic p;
    logic [13:0] o, e;
    blank = (w == 2) ? 0 : 2;
    lzb   = (w == 1);
    slot  = 4 + blank;
    fl    = 4 * slot;
    b     = 3 * slot + 3;
    wait_frame(w, n);
    if (exp_wait > 0) check($sformatf("frame_gap_w%0d", w), n, exp_wait);
    case (w)
      0: if (exp_q_a.size() > 0) cur[0] = exp_q_a.pop_front();
      1: if (exp_q_b.size() > 0) cur[1] = exp_q_b.pop_front();
      default: if (exp_q_c.size() > 0) cur[2] = exp_q_c.pop_front();
    endcase
    for (int t = 0; t < fl; t++) begin
      if (t > 0) @(negedge clk);
      o = obs(w);
      p = (upd_t >= 0) && (upd_t < b) && (t > upd_t) && (t <= b);
      e = exp_vec(cur[w], lzb, blank, t, p);
      check($sformatf("w%0d_d%06h_t%0d", w, cur[w], t), o, e);
      if (t == upd_t) drive_upd(w, nv);
      if (t == upd_t + 1) release_upd(w);
    end
  endtask

  initial begin
    int n;
    logic [13:0] o;
    for (int w = 0; w < 3; w++) begin
      set_in(w, 1'b0, 24'h0);
      cur[w] = 24'h0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++)
      check($sformatf("reset_w%0d", w), obs(w), {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
    check("reset_state", 32'(if_a.dbg_state), 32'(ST_BLANK));
    rst = 1'b0;

    @(negedge clk);
    o = obs(0); check("rel1_fs_a", {31'd0, o[12]}, 32'd0);
    o = obs(2); check("rel1_fs_c", {31'd0, o[12]}, 32'd1);
    @(negedge clk);
    o = obs(0); check("rel2_fs_a", {31'd0, o[12]}, 32'd1);
    o = obs(1); check("rel2_fs_b", {31'd0, o[12]}, 32'd1);
    check("rel2_state", 32'(if_a.dbg_state), 32'(ST_SHOW));

    drive_upd(0, {4'hF, 4'h0, 16'h1234});
    drive_upd(1, {4'hF, 4'h0, 16'h0070});
    drive_upd(2, {4'b0101, 4'b0001, 16'h5A3C});
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      release_upd(w);
      o = obs(w);
      check($sformatf("pend_set_w%0d", w), {31'd0, o[13]}, 32'd1);
    end

    check_frame(0, 0, -1, 24'h0);
    check_frame(0, 1, 13, {4'hF, 4'h0, 16'hABCD});
    check_frame(0, 1, -1, 24'h0);
    check_frame(0, 1, 21, {4'hF, 4'b1010, 16'h9F0E});
    check_frame(0, 1, -1, 24'h0);

    check_frame(1, 0, -1, 24'h0);
    check_frame(1, 1, 5, {4'hF, 4'h0, 16'h0000});
    check_frame(1, 1, -1, 24'h0);

    check_frame(2, 0, -1, 24'h0);
    check_frame(2, 1, -1, 24'h0);

    // Asynchronous reset in the middle of digit 0's SHOW.
    wait_frame(0, n);
    @(negedge clk);
    o = obs(0);
    check("pre_arst_sel", {28'd0, o[11:8]}, 32'hE);
    rst = 1'b1;
    #1;
    check("arst_out", obs(0), {1'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
    check("arst_state", 32'(if_a.dbg_state), 32'(ST_BLANK));
    cur[0] = 24'h0;
    exp_q_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_frame(0, 2, -1, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
